// File: rtl/pattern_loader.sv
// pattern_loader: samples a slow host serial port and turns each host bit into a one-cycle
// shift strobe for the pattern buffer. Define LOAD_PARITY_EN to append an even-parity bit per frame.
module pattern_loader #(
    parameter int BUFFER_SIZE  = 22,
    parameter int BUFFER_WIDTH = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic host_sclk,
    input  logic host_cs_n,
    input  logic host_sdi,
    output logic host_sdo,
    input  logic buf_sout,
    output logic ssel,
    output logic sin,
    output logic load_busy,
    output logic load_done,
    output logic frame_err,
    output logic [$clog2(BUFFER_SIZE*BUFFER_WIDTH+2)-1:0] bit_count
);

    localparam int TOTAL = BUFFER_SIZE * BUFFER_WIDTH;
    localparam int CW    = $clog2(TOTAL + 2);
`ifdef LOAD_PARITY_EN
    localparam int FRAME_LEN = TOTAL + 1;
`else
    localparam int FRAME_LEN = TOTAL;
`endif
    localparam int SAT_LEN = FRAME_LEN + 1;

    localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);
    localparam logic [CW-1:0] FRAME_C = CW'(FRAME_LEN);
    localparam logic [CW-1:0] SAT_C   = CW'(SAT_LEN);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;

    logic [0:0]    state_q, state_d;
    logic          ssel_q, ssel_d;
    logic          sin_q, sin_d;
    logic          ssel_dly_q, ssel_dly_d;
    logic          sdo_q, sdo_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [CW-1:0] count_q, count_d;
`ifdef LOAD_PARITY_EN
    logic          parity_q, parity_d;
`endif

    logic sclk_s;
    logic cs_s;
    logic sdi_s;
    logic rise;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], host_sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], host_cs_n};
        sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0], host_sdi};
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        sdi_s       = sdi_sync_q[SYNC_STAGES-1];
        sclk_prev_d = sclk_s;
        rise        = sclk_s & ~sclk_prev_q;
    end

    // ssel/sin form a strobe with no backpressure: the buffer must shift sin in on every
    // clk where ssel=1, and a rise can never produce ssel on two consecutive cycles.
    always_comb begin
        state_d    = state_q;
        ssel_d     = 1'b0;
        sin_d      = 1'b0;
        ssel_dly_d = ssel_q;
        sdo_d      = sdo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        count_d    = count_q;
`ifdef LOAD_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            IDLE: begin
                sdo_d = 1'b0;
                if (!cs_s) begin
                    state_d  = SHIFT;
                    err_d    = 1'b0;
                    count_d  = '0;
                    busy_d   = 1'b1;
                    sdo_d    = buf_sout;
`ifdef LOAD_PARITY_EN
                    parity_d = 1'b0;
`endif
                end
            end
            SHIFT: begin
                if (cs_s) begin
                    // Frame end takes priority over a coincident rise; that bit is dropped.
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    sdo_d   = 1'b0;
                    if (count_q == FRAME_C && !err_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    // One cycle after a strobe the buffer has shifted, so sout is the next old bit.
                    if (ssel_dly_q) begin
                        sdo_d = buf_sout;
                    end
                    if (rise) begin
                        if (count_q < TOTAL_C) begin
                            ssel_d   = 1'b1;
                            sin_d    = sdi_s;
                            count_d  = count_q + ONE_C;
`ifdef LOAD_PARITY_EN
                            parity_d = parity_q ^ sdi_s;
`endif
                        end
`ifdef LOAD_PARITY_EN
                        else if (count_q == TOTAL_C) begin
                            count_d = count_q + ONE_C;
                            if (sdi_s != parity_q) begin
                                err_d = 1'b1;
                            end
                        end
`endif
                        else begin
                            err_d   = 1'b1;
                            count_d = SAT_C;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                sdo_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            sdi_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            state_q     <= IDLE;
            ssel_q      <= 1'b0;
            sin_q       <= 1'b0;
            ssel_dly_q  <= 1'b0;
            sdo_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
`ifdef LOAD_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            sdi_sync_q  <= sdi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            state_q     <= state_d;
            ssel_q      <= ssel_d;
            sin_q       <= sin_d;
            ssel_dly_q  <= ssel_dly_d;
            sdo_q       <= sdo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            count_q     <= count_d;
`ifdef LOAD_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign ssel      = ssel_q;
    assign sin       = sin_q;
    assign host_sdo  = sdo_q;
    assign load_busy = busy_q;
    assign load_done = done_q;
    assign frame_err = err_q;
    assign bit_count = count_q;

endmodule
